// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioning path.
// Contents:
//   db_state_t      - per-channel debounce FSM state
//   DB_TICKS_DEF    - default stable-time qualification, in clk cycles
//   REPEAT_DLY_DEF  - default delay from accepted press to first auto-repeat
//   REPEAT_PER_DEF  - default spacing of later auto-repeat pulses
package btn_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  localparam int unsigned DB_TICKS_DEF   = 2_000_000;
  localparam int unsigned REPEAT_DLY_DEF = 50_000_000;
  localparam int unsigned REPEAT_PER_DEF = 10_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, stable-time debounce FSM,
// registered debounced level and one-cycle press/release pulses.
// Optional auto-repeat of btn_press while the button is held, enabled by
// the macro BTN_AUTO_REPEAT_EN (absent: one press pulse per accepted press).
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   btn_raw     in   raw, asynchronous, bouncing button pin
//   btn_level   out  debounced level (registered)
//   btn_press   out  one-cycle pulse on accepted 0->1 (and on auto-repeat)
//   btn_release out  one-cycle pulse on accepted 1->0
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DB_TICKS   = DB_TICKS_DEF,
  parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int unsigned REPEAT_PER = REPEAT_PER_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned CNT_W = $clog2(DB_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

  // Reject parameter sets the counters cannot represent.
  if (DB_TICKS < 2 || REPEAT_DLY == 0 || REPEAT_PER == 0) begin : g_bad_param
    $error("btn_debounce_ch: DB_TICKS must be >= 2 and REPEAT_* >= 1");
  end

  logic           sync_meta;
  logic           sync_s;
  db_state_t      state;
  db_state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic           level_c;
  logic           press_c;
  logic           release_c;
  logic           rep_fire_c;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_s    <= sync_meta;
    end
  end

  // FSM state and qualification counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ZERO;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: a level change is accepted only after DB_TICKS+1 consecutive
  // agreeing samples; any disagreement drops back without a pulse.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ZERO: begin
        if (sync_s) begin
          state_next = WAIT1;
          cnt_next   = '0;
        end
      end
      WAIT1: begin
        if (!sync_s) begin
          state_next = ZERO;
        end else if (cnt == CNT_LAST) begin
          state_next = ONE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ONE: begin
        if (!sync_s) begin
          state_next = WAIT0;
          cnt_next   = '0;
        end
      end
      WAIT0: begin
        if (sync_s) begin
          state_next = ONE;
        end else if (cnt == CNT_LAST) begin
          state_next = ZERO;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = ZERO;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered level and
  // its edge pulses appear on the same edge as the state change.
  always_comb begin
    level_c   = (state_next == ONE) || (state_next == WAIT0);
    press_c   = ((state == WAIT1) && (state_next == ONE)) || rep_fire_c;
    release_c = (state == WAIT0) && (state_next == ZERO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_level   <= level_c;
      btn_press   <= press_c;
      btn_release <= release_c;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DLY - 1);
  localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PER - 1);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_cnt_next;
  logic             rep_periodic;
  logic             rep_periodic_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt      <= '0;
      rep_periodic <= 1'b0;
    end else begin
      rep_cnt      <= rep_cnt_next;
      rep_periodic <= rep_periodic_next;
    end
  end

  // Counts only cycles that stay in ONE; WAIT0 freezes it, and it restarts
  // once the press has been released for good.
  always_comb begin
    rep_cnt_next      = rep_cnt;
    rep_periodic_next = rep_periodic;
    rep_fire_c        = 1'b0;
    if ((state == ONE) && sync_s) begin
      if (rep_cnt == (rep_periodic ? REP_PER_LAST : REP_DLY_LAST)) begin
        rep_fire_c        = 1'b1;
        rep_cnt_next      = '0;
        rep_periodic_next = 1'b1;
      end else begin
        rep_cnt_next = rep_cnt + REP_W'(1);
      end
    end else if ((state == ZERO) || (state == WAIT1)) begin
      rep_cnt_next      = '0;
      rep_periodic_next = 1'b0;
    end
  end
`else
  assign rep_fire_c = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Input stage for the reaction-test top: conditions the raw push buttons
// (bit 0 = BTNL, 1 = BTNC, 2 = BTNR) into debounced levels and one-cycle
// press/release pulses. Channels run fully in parallel.
// Optional auto-repeat on held buttons via macro BTN_AUTO_REPEAT_EN.
// Ports:
//   clk         in   system clock (100 MHz)
//   reset       in   asynchronous, active-high reset
//   btn_raw     in   [N_BTN] raw bouncing button pins
//   btn_level   out  [N_BTN] debounced levels (registered)
//   btn_press   out  [N_BTN] one-cycle accepted-press pulses
//   btn_release out  [N_BTN] one-cycle accepted-release pulses
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN      = 3,
  parameter int unsigned DB_TICKS   = DB_TICKS_DEF,
  parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int unsigned REPEAT_PER = REPEAT_PER_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // One independent conditioner per button.
  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_debounce_ch #(
      .DB_TICKS  (DB_TICKS),
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with short sim timing (DB_TICKS=4,
// REPEAT_DLY=8, REPEAT_PER=3). Directed vector table, hand-written reset and
// auto-repeat sequences, then random bouncing stimulus against a reference
// model built on sample history and run lengths.
module tb_btn_conditioner;

  localparam int unsigned DBT  = 4;
  localparam int unsigned RDLY = 8;
  localparam int unsigned RPER = 3;
  localparam int NVEC = 84;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN     (3),
    .DB_TICKS  (DBT),
    .REPEAT_DLY(RDLY),
    .REPEAT_PER(RPER)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  typedef struct {
    logic [2:0] raw;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
  } vec_t;

  vec_t tbl [NVEC];

  // Reference model: the synchronized value at edge e is the raw value
  // sampled at edge e-2; a level flips once DBT+1 consecutive samples
  // disagree with it. Held cycles count toward auto-repeat.
  logic [2:0] hist [$];
  logic [2:0] m_level, m_press, m_release;
  int         run    [3];
  logic       prev_s [3];
  int         hold   [3];

  function automatic void model_reset();
    hist.delete();
    m_level   = 3'b000;
    m_press   = 3'b000;
    m_release = 3'b000;
    for (int c = 0; c < 3; c++) begin
      run[c]    = 0;
      prev_s[c] = 1'b0;
      hold[c]   = 0;
    end
  endfunction

  function automatic void model_step();
    logic [2:0] s_now;
    if (reset) begin
      model_reset();
      return;
    end
    hist.push_back(btn_raw);
    s_now = (hist.size() >= 3) ? hist[hist.size() - 3] : 3'b000;
    if (hist.size() > 3) void'(hist.pop_front());
    m_press   = 3'b000;
    m_release = 3'b000;
    for (int c = 0; c < 3; c++) begin
      logic prev;
      prev = prev_s[c];
      if (s_now[c] == prev) run[c]++;
      else run[c] = 1;
      prev_s[c] = s_now[c];
      if (!m_level[c] && s_now[c] && run[c] >= int'(DBT) + 1) begin
        m_level[c] = 1'b1;
        m_press[c] = 1'b1;
        hold[c]    = 0;
      end else if (m_level[c] && !s_now[c] && run[c] >= int'(DBT) + 1) begin
        m_level[c]   = 1'b0;
        m_release[c] = 1'b1;
      end else if (m_level[c] && prev && s_now[c]) begin
        hold[c]++;
`ifdef BTN_AUTO_REPEAT_EN
        if (hold[c] >= int'(RDLY) && ((hold[c] - int'(RDLY)) % int'(RPER)) == 0)
          m_press[c] = 1'b1;
`endif
      end
    end
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: {level,press,release} got %b required %b", name, act, exp);
  endtask

  // Drive one input vector, advance one clock, sample at the falling edge.
  task automatic step(input logic [2:0] r);
    btn_raw = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  logic [2:0] cur;
  int         rem [3];
  int         n_rep_press, n_rep_rel, first_press;

  initial begin
    reset   = 1'b1;
    btn_raw = 3'b111;
    model_reset();
    @(negedge clk);

    // Buttons held through reset: silent during reset, one press afterwards.
    for (int i = 0; i < 5; i++) begin
      step(3'b111);
      check("in_reset", {btn_level, btn_press, btn_release}, 9'b0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(3'b111);
      check($sformatf("held_reset_e%0d", i), {btn_level, btn_press, btn_release},
            {(i >= 7) ? 3'b111 : 3'b000, (i == 7) ? 3'b111 : 3'b000, 3'b000});
    end

    // Reset while pressed clears level with no release pulse.
    reset = 1'b1;
    step(3'b000);
    check("reset_clears", {btn_level, btn_press, btn_release}, 9'b0);
    step(3'b000);

    // Reset mid-qualification discards progress.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(3'b010);
      check("midq_before", {btn_level, btn_press, btn_release}, 9'b0);
    end
    reset = 1'b1;
    step(3'b010);
    step(3'b010);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(3'b000);
      check("midq_after", {btn_level, btn_press, btn_release}, 9'b0);
    end

    // Directed table: clean BTNC press/release, BTNR glitch, BTNC bounce,
    // BTNL press held 20 cycles.
    for (int i = 0; i < NVEC; i++) begin
      tbl[i].raw[1] = (i < 10) || (i == 30) || (i == 32) || (i >= 34 && i < 45);
      tbl[i].raw[2] = (i >= 20 && i <= 22);
      tbl[i].raw[0] = (i >= 52 && i < 72);
      tbl[i].lvl[1] = (i >= 6 && i < 16) || (i >= 40 && i < 51);
      tbl[i].lvl[2] = 1'b0;
      tbl[i].lvl[0] = (i >= 58 && i < 78);
      tbl[i].prs[1] = (i == 6) || (i == 40);
      tbl[i].prs[2] = 1'b0;
      tbl[i].prs[0] = (i == 58);
`ifdef BTN_AUTO_REPEAT_EN
      if (i == 66 || i == 69 || i == 72) tbl[i].prs[0] = 1'b1;
`endif
      tbl[i].rel[1] = (i == 16) || (i == 51);
      tbl[i].rel[2] = 1'b0;
      tbl[i].rel[0] = (i == 78);
    end
    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].raw);
      check($sformatf("vec%0d", i), {btn_level, btn_press, btn_release},
            {tbl[i].lvl, tbl[i].prs, tbl[i].rel});
    end

    // BTNC held 40 cycles: auto-repeat pulses only with the macro.
    for (int i = 0; i < 4; i++) step(3'b000);
    n_rep_press = 0;
    n_rep_rel   = 0;
    first_press = -1;
    for (int i = 0; i < 52; i++) begin
      step((i < 40) ? 3'b010 : 3'b000);
      if (btn_press[1]) begin
        n_rep_press++;
        if (first_press < 0) first_press = i;
      end
      if (btn_release[1]) n_rep_rel++;
    end
    n_total++;
    if (first_press == 6) n_pass++;
    else $display("FAIL hold_first_press: at cycle %0d required 6", first_press);
    n_total++;
`ifdef BTN_AUTO_REPEAT_EN
    if (n_rep_press == 11) n_pass++;
    else $display("FAIL hold_press_count: got %0d required 11", n_rep_press);
`else
    if (n_rep_press == 1) n_pass++;
    else $display("FAIL hold_press_count: got %0d required 1", n_rep_press);
`endif
    n_total++;
    if (n_rep_rel == 1) n_pass++;
    else $display("FAIL hold_release_count: got %0d required 1", n_rep_rel);

    // Random bouncing on all channels, with one reset in the middle.
    cur = 3'b000;
    for (int c = 0; c < 3; c++) rem[c] = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          cur[c] = ~cur[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 16));
        end
        rem[c]--;
      end
      reset = (k >= 700 && k < 702);
      step(cur);
      check($sformatf("rand%0d", k), {btn_level, btn_press, btn_release},
            {m_level, m_press, m_release});
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
